// File: rtl/ce_rr_load_arbiter.sv
// Round-robin arbiter that owns the clock-enable of a shared preset-to-INIT register.
// Define CE_ARB_HOLD_EN to let a LOCK-holding winner chain up to HOLD_MAX writes.
module ce_rr_load_arbiter #(
   parameter int          N        = 4,
   parameter int          W        = 8,
   parameter logic [W-1:0] INIT    = {W{1'b1}},
   parameter int          HOLD_MAX = 4
) (
   input  logic                   C,
   input  logic                   CLR,
   input  logic [N-1:0]           REQ,
   input  logic [N-1:0]           LOCK,
   input  logic [N*W-1:0]         DIN,
   output logic [N-1:0]           GNT,
   output logic [N-1:0]           ACK,
   output logic [W-1:0]           Q,
   output logic                   WR_STB,
   output logic                   BUSY,
   output logic [$clog2(N)-1:0]   WINNER
);

   // state    | meaning
   // ST_IDLE  | no grant; round-robin search over REQ starting at ptr_q
   // ST_GRANT | GNT held; closing edge loads DIN[winner] into Q
   // ST_DONE  | Q shows new data, ACK/WR_STB pulse; return to idle or re-grant
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int IW = $clog2(N);
   localparam int SW = IW + 1;

   state_t         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [N-1:0]   ack_q, ack_d;
   logic           wr_stb_q, wr_stb_d;
   logic           busy_q, busy_d;
   logic [W-1:0]   q_q, q_d;
   logic [IW-1:0]  winner_q, winner_d;
   logic [IW-1:0]  ptr_q, ptr_d;

   logic           pick_found;
   logic [IW-1:0]  pick_idx;
   logic [SW-1:0]  pick_sum;
   logic [IW-1:0]  ptr_next;
   logic [W-1:0]   din_sel;
   logic           hold_take;

   // Walk the candidates from the far end so the last hit is the one closest to ptr_q.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_sum   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         pick_sum = {1'b0, ptr_q} + SW'(j);
         if (pick_sum >= SW'(N)) begin
            pick_sum = pick_sum - SW'(N);
         end
         if (REQ[pick_sum[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = pick_sum[IW-1:0];
         end
      end
   end

   assign ptr_next = (winner_q == IW'(N - 1)) ? '0 : winner_q + 1'b1;
   assign din_sel  = DIN[winner_q*W +: W];

`ifdef CE_ARB_HOLD_EN
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   // Remaining chained writes the current winner may still take without re-arbitration.
   logic [HW-1:0] hold_left_q, hold_left_d;

   assign hold_take = LOCK[winner_q] & REQ[winner_q] & (hold_left_q != '0);

   always_comb begin
      hold_left_d = hold_left_q;
      if (state_q == ST_IDLE && pick_found) begin
         hold_left_d = HW'(HOLD_MAX - 1);
      end else if (state_q == ST_DONE) begin
         hold_left_d = hold_take ? hold_left_q - 1'b1 : '0;
      end
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         hold_left_q <= '0;
      end else begin
         hold_left_q <= hold_left_d;
      end
   end
`else
   localparam int HOLD_UNUSED = HOLD_MAX;
   logic lock_unused;

   assign lock_unused = ^LOCK;
   assign hold_take   = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ack_d    = '0;
      wr_stb_d = 1'b0;
      q_d      = q_q;
      winner_d = winner_q;
      ptr_d    = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d           = ST_GRANT;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
               winner_d          = pick_idx;
            end
         end
         ST_GRANT: begin
            q_d      = din_sel;
            ack_d    = gnt_q;
            wr_stb_d = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            if (hold_take) begin
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               ptr_d   = ptr_next;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         ack_q    <= '0;
         wr_stb_q <= 1'b0;
         busy_q   <= 1'b0;
         q_q      <= INIT;
         winner_q <= '0;
         ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         wr_stb_q <= wr_stb_d;
         busy_q   <= busy_d;
         q_q      <= q_d;
         winner_q <= winner_d;
         ptr_q    <= ptr_d;
      end
   end

   assign GNT    = gnt_q;
   assign ACK    = ack_q;
   assign WR_STB = wr_stb_q;
   assign BUSY   = busy_q;
   assign Q      = q_q;
   assign WINNER = winner_q;

endmodule

// File: tb/tb_ce_rr_load_arbiter.sv
// Bench for ce_rr_load_arbiter (N=4, W=8): vector table, directed corner sequences,
// and random traffic against a transaction-level model.
module tb_ce_rr_load_arbiter;

   localparam int N = 4;
   localparam int W = 8;
`ifdef CE_ARB_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   localparam int HOLD_MAX = 4;

   logic          C = 1'b0;
   logic          CLR;
   logic [N-1:0]  REQ;
   logic [N-1:0]  LOCK;
   logic [N*W-1:0] DIN;
   logic [N-1:0]  GNT;
   logic [N-1:0]  ACK;
   logic [W-1:0]  Q;
   logic          WR_STB;
   logic          BUSY;
   logic [1:0]    WINNER;

   int total = 0;
   int bad   = 0;

   ce_rr_load_arbiter #(.N(N), .W(W), .INIT(8'hFF), .HOLD_MAX(HOLD_MAX)) dut (
      .C(C), .CLR(CLR), .REQ(REQ), .LOCK(LOCK), .DIN(DIN),
      .GNT(GNT), .ACK(ACK), .Q(Q), .WR_STB(WR_STB), .BUSY(BUSY), .WINNER(WINNER)
   );

   always #5 C = ~C;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [3:0] ack;
      logic [7:0] q;
      logic       wr;
      logic       busy;
      logic [1:0] win;
   } vec_t;

   vec_t tbl[12];

   // Transaction-level model: phase 0 idle, 1 granted, 2 written
   int         m_phase, m_win, m_ptr, m_burst;
   logic [7:0] m_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge C);
      @(negedge C);
   endtask

   task automatic model_reset();
      m_phase = 0; m_win = 0; m_ptr = 0; m_burst = 0; m_q = 8'hFF;
   endtask

   task automatic model_step(input logic [3:0] req, input logic [3:0] lock, input logic [31:0] din);
      int k;
      case (m_phase)
         0: begin
            if (req != 0) begin
               for (int j = 0; j < N; j++) begin
                  k = (m_ptr + j) % N;
                  if (req[k]) begin
                     m_win = k;
                     m_phase = 1;
                     break;
                  end
               end
            end
         end
         1: begin
            m_q = din[m_win*8 +: 8];
            m_phase = 2;
         end
         default: begin
            if (HOLD && lock[m_win] && req[m_win] && m_burst < HOLD_MAX - 1) begin
               m_burst++;
               m_phase = 1;
            end else begin
               m_burst = 0;
               m_ptr = (m_win + 1) % N;
               m_phase = 0;
            end
         end
      endcase
   endtask

   task automatic model_check();
      logic [3:0] eg;
      eg = (m_phase != 0) ? 4'(1 << m_win) : 4'b0;
      chk("rnd_gnt", 32'(GNT), 32'(eg));
      chk("rnd_ack", 32'(ACK), (m_phase == 2) ? 32'(eg) : 32'd0);
      chk("rnd_q", 32'(Q), 32'(m_q));
      chk("rnd_wr", 32'(WR_STB), (m_phase == 2) ? 32'd1 : 32'd0);
      chk("rnd_busy", 32'(BUSY), (m_phase != 0) ? 32'd1 : 32'd0);
      chk("rnd_win", 32'(WINNER), 32'(m_win));
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic pulse_clr();
      #1 CLR = 1'b1;
      #1 CLR = 1'b0;
   endtask

   initial begin
      int seen[$];
      int cyc[$];
      logic [3:0] prev_gnt;

      CLR = 1'b1; REQ = '0; LOCK = '0; DIN = '0;
      #1;
      chk("por_q", 32'(Q), 32'hFF);
      chk("por_gnt", 32'(GNT), 32'h0);
      chk("por_busy", 32'(BUSY), 32'h0);
      @(negedge C);
      CLR = 1'b0;

      // Contention from reset: every requester drops REQ after its own ACK.
      tbl[0]  = '{4'b1111, 4'b0001, 4'b0000, 8'hFF, 1'b0, 1'b1, 2'd0};
      tbl[1]  = '{4'b1111, 4'b0001, 4'b0001, 8'h10, 1'b1, 1'b1, 2'd0};
      tbl[2]  = '{4'b1110, 4'b0000, 4'b0000, 8'h10, 1'b0, 1'b0, 2'd0};
      tbl[3]  = '{4'b1110, 4'b0010, 4'b0000, 8'h10, 1'b0, 1'b1, 2'd1};
      tbl[4]  = '{4'b1110, 4'b0010, 4'b0010, 8'h11, 1'b1, 1'b1, 2'd1};
      tbl[5]  = '{4'b1100, 4'b0000, 4'b0000, 8'h11, 1'b0, 1'b0, 2'd1};
      tbl[6]  = '{4'b1100, 4'b0100, 4'b0000, 8'h11, 1'b0, 1'b1, 2'd2};
      tbl[7]  = '{4'b1100, 4'b0100, 4'b0100, 8'h12, 1'b1, 1'b1, 2'd2};
      tbl[8]  = '{4'b1000, 4'b0000, 4'b0000, 8'h12, 1'b0, 1'b0, 2'd2};
      tbl[9]  = '{4'b1000, 4'b1000, 4'b0000, 8'h12, 1'b0, 1'b1, 2'd3};
      tbl[10] = '{4'b1000, 4'b1000, 4'b1000, 8'h13, 1'b1, 1'b1, 2'd3};
      tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 8'h13, 1'b0, 1'b0, 2'd3};
      DIN = 32'h13121110;
      for (int i = 0; i < 12; i++) begin
         REQ = tbl[i].req;
         tick();
         chk($sformatf("tbl%0d_gnt", i), 32'(GNT), 32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_ack", i), 32'(ACK), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d_q", i), 32'(Q), 32'(tbl[i].q));
         chk($sformatf("tbl%0d_wr", i), 32'(WR_STB), 32'(tbl[i].wr));
         chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d_win", i), 32'(WINNER), 32'(tbl[i].win));
      end

      // Asynchronous clear between edges, no clock involved.
      #2 CLR = 1'b1;
      #1;
      chk("aclr_q", 32'(Q), 32'hFF);
      chk("aclr_win", 32'(WINNER), 32'h0);
      chk("aclr_busy", 32'(BUSY), 32'h0);
      #1 CLR = 1'b0;
      @(negedge C);

      // Single write by requester 2 (ptr 0 after clear).
      REQ = 4'b0100; DIN = 32'h003C0000;
      tick();
      chk("sw_gnt", 32'(GNT), 32'h4);
      chk("sw_q_hold", 32'(Q), 32'hFF);
      chk("sw_ack0", 32'(ACK), 32'h0);
      tick();
      REQ = 4'b0000;
      chk("sw_q", 32'(Q), 32'h3C);
      chk("sw_ack", 32'(ACK), 32'h4);
      chk("sw_wr", 32'(WR_STB), 32'h1);
      tick();
      chk("sw_idle", 32'(BUSY), 32'h0);
      chk("sw_ack_gone", 32'(ACK), 32'h0);
      chk("sw_q_keep", 32'(Q), 32'h3C);

      // Fairness and wrap: last winner 2, REQ 1001 held continuously.
      REQ = 4'b1001;
      prev_gnt = GNT;
      seen.delete();
      for (int c = 0; c < 30 && seen.size() < 4; c++) begin
         tick();
         if (GNT != 0 && prev_gnt == 0) seen.push_back(int'(WINNER));
         prev_gnt = GNT;
      end
      chk("fair_count", 32'(seen.size()), 32'd4);
      for (int i = 0; i < seen.size(); i++)
         chk($sformatf("fair_order%0d", i), 32'(seen[i]), (i % 2 == 0) ? 32'd3 : 32'd0);
      REQ = 4'b0000;
      for (int c = 0; c < 5 && BUSY; c++) tick();
      chk("fair_drain", 32'(BUSY), 32'h0);

      // Clear while in GRANT abandons the write.
      pulse_clr();
      REQ = 4'b0001; DIN = 32'h00000055;
      tick();
      chk("mid_gnt", 32'(GNT), 32'h1);
      #2 CLR = 1'b1;
      #1;
      chk("mid_gnt_clr", 32'(GNT), 32'h0);
      chk("mid_busy_clr", 32'(BUSY), 32'h0);
      #1 CLR = 1'b0;
      REQ = 4'b0010; DIN = 32'h00007755;
      tick();
      chk("mid_q_kept", 32'(Q), 32'hFF);
      chk("mid_no_ack", 32'(ACK), 32'h0);
      chk("mid_regnt", 32'(GNT), 32'h2);
      tick();
      REQ = 4'b0000;
      chk("mid_q_new", 32'(Q), 32'h77);
      chk("mid_ack", 32'(ACK), 32'h2);
      tick();

      // Locked requester 1 against requester 0.
      pulse_clr();
      REQ = 4'b0010; LOCK = 4'b0010; DIN = 32'h0000B1A0;
      tick();
      REQ = 4'b0011;
      seen.delete(); cyc.delete();
      for (int c = 0; c < 40 && seen.size() < 5; c++) begin
         tick();
         if (ACK != 0) begin
            seen.push_back(onehot_idx(ACK));
            cyc.push_back(c);
         end
      end
      chk("hold_count", 32'(seen.size()), 32'd5);
      for (int i = 0; i < seen.size(); i++) begin
         if (HOLD) chk($sformatf("hold_who%0d", i), 32'(seen[i]), (i < 4) ? 32'd1 : 32'd0);
         else      chk($sformatf("hold_who%0d", i), 32'(seen[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      if (cyc.size() >= 2) chk("hold_spacing", 32'(cyc[1] - cyc[0]), HOLD ? 32'd2 : 32'd3);
      REQ = '0; LOCK = '0;

      // Random traffic against the model.
      @(negedge C);
      pulse_clr();
      model_reset();
      model_check();
      for (int c = 0; c < 400; c++) begin
         REQ  = 4'($urandom_range(0, 15));
         LOCK = 4'($urandom_range(0, 15));
         DIN  = $urandom;
         model_step(REQ, LOCK, DIN);
         tick();
         model_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ce_rr_load_arbiter.md
Name: ce_rr_load_arbiter

Overview:
- Shares one W-bit clock-enabled, preset-to-INIT holding register between N requesters.
- Arbitrates requests round-robin and generates the register's clock-enable.
- Loads the granted requester's data and returns a per-requester acknowledge.
- Sits between PicoBlaze-side port writers and a shared configuration/output latch.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, data width.
- INIT, {W{1'b1}}, value of Q after reset (preset semantics, all ones).
- HOLD_MAX, 4, maximum consecutive locked writes per grant; only used with CE_ARB_HOLD_EN.

Ports:
- C  in  1  clock, rising edge.
- CLR  in  1  asynchronous reset, active-high.
- REQ  in  N  per-requester load request, level.
- LOCK  in  N  per-requester burst hold; ignored unless CE_ARB_HOLD_EN.
- DIN  in  N*W  packed data; requester i occupies bits [i*W +: W].
- GNT  out  N  one-hot grant, registered.
- ACK  out  N  one-cycle write-done pulse to the granted requester.
- Q  out  W  shared register contents.
- WR_STB  out  1  high for exactly the cycle in which Q first shows newly loaded data.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- WINNER  out  clog2(N)  index of the current or last granted requester.

Behaviour:
- CLR high, asynchronous, dominates everything, including mid-operation:
  - state=IDLE, GNT=0, ACK=0, WR_STB=0, BUSY=0.
  - Q=INIT, WINNER=0, round-robin pointer PTR=0, burst count=0.
  - Any in-flight write is abandoned; no ACK is issued.
- FSM states are IDLE, GRANT, DONE. All outputs are registered.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the first i with REQ[i]=1, searching PTR, PTR+1, … modulo N.
  - Next edge: GNT=onehot(i), WINNER=i, state=GRANT.
- GRANT (exactly 1 cycle):
  - At the closing edge: Q<=DIN[WINNER] (internal CE active for this edge only), state=DONE.
  - DIN is sampled at this edge only.
  - Dropping REQ during GRANT does not cancel the write.
- DONE (exactly 1 cycle):
  - ACK[WINNER]=1 and WR_STB=1; GNT stays asserted.
  - At the closing edge: GNT=0, ACK=0, PTR=(WINNER+1) mod N, state=IDLE.
  - This applies unless the hold path below is taken.
- Q changes only at the GRANT→DONE edge. Otherwise Q holds its value (clock-enable low).
- Latency:
  - REQ sampled high in IDLE at edge k → GNT high after k, Q updated and ACK high after k+1, idle after k+2.
  - One requester can therefore write at most once every 3 cycles.
- Requesters deassert REQ on seeing ACK. A REQ still high when the FSM returns to IDLE counts as a new request and competes normally.
- Simultaneous requests are resolved by PTR alone; no requester is served twice before every other pending requester is served.
- WINNER indexes beyond N-1 never occur.
- Wrap-around: PTR after requester N-1 is 0.

Optional Feature:
- Macro: CE_ARB_HOLD_EN.
- Defined:
  - In DONE, if LOCK[WINNER]=1, REQ[WINNER]=1 and burst count < HOLD_MAX-1: next state=GRANT with the same WINNER.
  - In that case GNT stays high, there is no IDLE gap, PTR is unchanged and burst count increments.
  - Locked burst throughput is one write every 2 cycles.
  - When the limit is reached or LOCK drops, take the normal DONE→IDLE path and clear the burst count.
- Not defined:
  - LOCK is ignored, the burst counter is not built, and HOLD_MAX has no effect.
  - Behaviour is exactly as described above.

Test Plan:
- Power-up/CLR: assert CLR asynchronously between edges → Q=8'hFF, GNT=0, ACK=0, BUSY=0 immediately, without waiting for C.
- Single write: REQ=4'b0100, DIN[2]=8'h3C → GNT=4'b0100 one edge later; Q=8'h3C, ACK=4'b0100 and WR_STB=1 for one cycle on the next edge; IDLE after 3 cycles total.
- Contention: REQ=4'b1111 held, each requester deasserting on its own ACK, DIN[i]=8'h10+i → grant order 0,1,2,3; Q sequence 10,11,12,13; exactly one ACK per requester.
- Fairness/wrap: PTR=3 (last winner 2), REQ=4'b1001 → requester 3 is granted, then 0. Repeat with REQ held continuously → strict alternation 3,0,3,0.
- Reset mid-operation: CLR pulsed while in GRANT with DIN=8'h55 → Q stays 8'hFF, no ACK, PTR=0; after release, pending REQ=4'b0010 is granted normally.
- With CE_ARB_HOLD_EN and HOLD_MAX=4: REQ[1]=LOCK[1]=1 held, REQ[0]=1 → four writes by requester 1 at a 2-cycle spacing, then IDLE, then requester 0 granted. Without the macro, the same stimulus alternates 1,0.
